// File: rtl/mstore_drain_if.sv
// Handshake bundle between the FFT output, the metadata store and the
// aligned data+metadata stream produced by mstore_drain.
interface mstore_drain_if #(
  parameter int WIDTH  = 32,
  parameter int MWIDTH = 1
);
  logic              in_m_nd;
  logic              in_nd;
  logic [WIDTH-1:0]  in_data;
  logic [MWIDTH-1:0] mstore_m;
  logic              mstore_read;
  logic              out_nd;
  logic [WIDTH-1:0]  out_data;
  logic [MWIDTH-1:0] out_m;
  logic              out_first;
  logic              out_last;
  logic              error;

  modport master (
    output in_m_nd, in_nd, in_data, mstore_m,
    input  mstore_read, out_nd, out_data, out_m,
    input  out_first, out_last, error
  );

  modport slave (
    input  in_m_nd, in_nd, in_data, mstore_m,
    output mstore_read, out_nd, out_data, out_m,
    output out_first, out_last, error
  );
endinterface

// File: rtl/mstore_drain.sv
// Read-side sequencer for an N-entry metadata store: tracks fill/drain,
// pairs each FFT sample with its metadata and strobes the store read.
module mstore_drain #(
  parameter int N      = 8,
  parameter int WIDTH  = 32,
  parameter int MWIDTH = 1
) (
  input logic          clk,
  input logic          rst_n,
  mstore_drain_if.slave bus
);

  localparam int CW = $clog2(N);
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  typedef enum logic {
    FILL,
    DRAIN
  } state_e;

  state_e            state_q, state_d;
  logic [CW-1:0]     wcount_q, wcount_d;
  logic [CW-1:0]     rcount_q, rcount_d;
  logic              read_q, read_d;
  logic              nd_q, nd_d;
  logic              first_q, first_d;
  logic              last_q, last_d;
  logic              err_q, err_d;
  logic [WIDTH-1:0]  data_q, data_d;
  logic [MWIDTH-1:0] m_q, m_d;

  logic          final_rd;
  logic          accept;
  logic [CW-1:0] idx;

  function automatic logic [CW-1:0] inc(input logic [CW-1:0] v);
    return (v == LAST) ? '0 : v + 1'b1;
  endfunction

  // A read in flight this cycle already owns rcount, so the sample
  // being accepted takes the following index.
  assign final_rd = (state_q == DRAIN) && read_q && (rcount_q == LAST);
  assign idx      = read_q ? inc(rcount_q) : rcount_q;
  assign accept   = bus.in_nd && (state_q == DRAIN) && !final_rd;

  always_comb begin
    state_d  = state_q;
    wcount_d = wcount_q;
    rcount_d = rcount_q;
    err_d    = err_q;
    data_d   = data_q;
    m_d      = m_q;
    read_d   = 1'b0;
    nd_d     = 1'b0;
    first_d  = 1'b0;
    last_d   = 1'b0;

    if (read_q) rcount_d = inc(rcount_q);

    unique case (state_q)
      FILL: begin
        if (bus.in_m_nd) begin
          wcount_d = inc(wcount_q);
          if (wcount_q == LAST) state_d = DRAIN;
        end
        if (bus.in_nd) err_d = 1'b1;
      end
      DRAIN: begin
        if (bus.in_m_nd) err_d = 1'b1;
        if (bus.in_nd && final_rd) err_d = 1'b1;
        if (final_rd) state_d = FILL;
      end
    endcase

    if (accept) begin
      nd_d    = 1'b1;
      read_d  = 1'b1;
      data_d  = bus.in_data;
      m_d     = bus.mstore_m;
      first_d = (idx == '0);
      last_d  = (idx == LAST);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= FILL;
      wcount_q <= '0;
      rcount_q <= '0;
      read_q   <= 1'b0;
      nd_q     <= 1'b0;
      first_q  <= 1'b0;
      last_q   <= 1'b0;
      err_q    <= 1'b0;
      data_q   <= '0;
      m_q      <= '0;
    end else begin
      state_q  <= state_d;
      wcount_q <= wcount_d;
      rcount_q <= rcount_d;
      read_q   <= read_d;
      nd_q     <= nd_d;
      first_q  <= first_d;
      last_q   <= last_d;
      err_q    <= err_d;
      data_q   <= data_d;
      m_q      <= m_d;
    end
  end

  assign bus.mstore_read = read_q;
  assign bus.out_nd      = nd_q;
  assign bus.out_data    = data_q;
  assign bus.out_m       = m_q;
  assign bus.out_first   = first_q;
  assign bus.out_last    = last_q;
  assign bus.error       = err_q;

endmodule

// File: tb/tb_mstore_drain.sv
// Directed bench for mstore_drain (N=4) with a small behavioural
// metadata store standing in for the real mstore.
module tb_mstore_drain;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  logic wm    = 1'b0;

  always #5 clk = ~clk;

  mstore_drain_if #(.WIDTH(32), .MWIDTH(1)) bus ();

  mstore_drain #(
    .N(4),
    .WIDTH(32),
    .MWIDTH(1)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );

  // store stub: shows RAM[rp], or RAM[rp+1] while the read is high
  logic [0:0] ram [4];
  logic [1:0] wp, rp;

  always_ff @(posedge clk)
    if (rst_n && bus.in_m_nd) ram[wp] <= wm;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wp <= '0;
      rp <= '0;
    end else begin
      if (bus.in_m_nd) wp <= wp + 2'd1;
      if (bus.mstore_read) rp <= rp + 2'd1;
    end
  end

  assign bus.mstore_m = bus.mstore_read ? ram[rp + 2'd1] : ram[rp];

  int n_run  = 0;
  int n_fail = 0;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle;
    bus.in_m_nd = 1'b0;
    bus.in_nd   = 1'b0;
    bus.in_data = '0;
  endtask

  task automatic do_reset;
    idle();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic write_n(input logic [3:0] m, input int n);
    for (int i = 0; i < n; i++) begin
      bus.in_m_nd = 1'b1;
      wm = m[i];
      tick();
    end
    idle();
  endtask

  task automatic drain4(input logic [3:0] m, input int base,
                        input int gap, input bit clean);
    for (int i = 0; i < 4; i++) begin
      bus.in_nd   = 1'b1;
      bus.in_data = base + i;
      tick();
      idle();
      check($sformatf("nd%0d", i), bus.out_nd, 1);
      check($sformatf("rd%0d", i), bus.mstore_read, 1);
      check($sformatf("data%0d", i), bus.out_data, base + i);
      check($sformatf("m%0d", i), bus.out_m, m[i]);
      check($sformatf("first%0d", i), bus.out_first, (i == 0));
      check($sformatf("last%0d", i), bus.out_last, (i == 3));
      for (int g = 0; g < gap; g++) begin
        tick();
        check("gap_nd", bus.out_nd, 0);
        check("gap_rd", bus.mstore_read, 0);
        check("gap_hold", bus.out_data, base + i);
      end
    end
    tick();
    check("end_nd", bus.out_nd, 0);
    check("end_rd", bus.mstore_read, 0);
    if (clean) check("end_err", bus.error, 0);
  endtask

  initial begin
    idle();
    #2 rst_n = 1'b0;
    #1;
    check("rst_nd", bus.out_nd, 0);
    check("rst_rd", bus.mstore_read, 0);
    check("rst_err", bus.error, 0);
    check("rst_data", bus.out_data, 0);
    check("rst_first", bus.out_first, 0);
    tick();
    rst_n = 1'b1;
    tick();

    // basic frame
    write_n(4'b1101, 4);
    check("fill_err", bus.error, 0);
    drain4(4'b1101, 10, 0, 1'b1);

    // gapped drain
    write_n(4'b1101, 4);
    drain4(4'b1101, 10, 2, 1'b1);

    // two frames back-to-back
    write_n(4'b1101, 4);
    drain4(4'b1101, 20, 0, 1'b1);
    write_n(4'b0100, 4);
    drain4(4'b0100, 30, 0, 1'b1);

    // early sample
    do_reset();
    write_n(4'b1111, 3);
    bus.in_nd   = 1'b1;
    bus.in_data = 32'd99;
    tick();
    idle();
    check("early_nd", bus.out_nd, 0);
    check("early_rd", bus.mstore_read, 0);
    check("early_err", bus.error, 1);
    tick();
    check("early_nd2", bus.out_nd, 0);

    // late write on the final read cycle
    do_reset();
    write_n(4'b1101, 4);
    for (int i = 0; i < 4; i++) begin
      bus.in_nd   = 1'b1;
      bus.in_data = 40 + i;
      tick();
    end
    idle();
    check("late_rd", bus.mstore_read, 1);
    check("late_pre_err", bus.error, 0);
    bus.in_m_nd = 1'b1;
    tick();
    idle();
    check("late_err", bus.error, 1);
    write_n(4'b0000, 3);
    bus.in_nd = 1'b1;
    tick();
    idle();
    check("late_wcount", bus.out_nd, 0);

    // async reset mid-drain
    do_reset();
    write_n(4'b1111, 4);
    for (int i = 0; i < 2; i++) begin
      bus.in_nd   = 1'b1;
      bus.in_data = 50 + i;
      tick();
    end
    idle();
    check("pre_rst_nd", bus.out_nd, 1);
    check("pre_rst_m", bus.out_m, 1);
    #2 rst_n = 1'b0;
    #1;
    check("arst_nd", bus.out_nd, 0);
    check("arst_rd", bus.mstore_read, 0);
    check("arst_data", bus.out_data, 0);
    check("arst_m", bus.out_m, 0);
    check("arst_first", bus.out_first, 0);
    check("arst_last", bus.out_last, 0);
    check("arst_err", bus.error, 0);
    #3 rst_n = 1'b1;
    tick();
    write_n(4'b1101, 4);
    drain4(4'b1101, 10, 0, 1'b1);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule

// File: doc/mstore_drain.md
Name: mstore_drain

Overview:
- Read-side sequencer for an N-entry metadata store of the `mstore` type, placed at the FFT output.
- Tracks the store's fill/drain phase by monitoring metadata writes.
- Pairs each outgoing FFT sample with its stored metadata word and drives the store's read strobe.
- Emits the aligned data+metadata stream with frame markers, and a sticky protocol error.

Parameters:
- N, 8, frame length = entries in the store (N >= 2).
- WIDTH, 32, FFT data sample width.
- MWIDTH, 1, metadata word width (must match the store).

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_m_nd  input  1  metadata write strobe, the same signal driven into the store's in_nd; monitored only.
- in_nd  input  1  FFT output sample valid.
- in_data  input  WIDTH  FFT output sample.
- mstore_m  input  MWIDTH  store's out_m (combinational from the store).
- mstore_read  output  1  drives the store's in_read.
- out_nd  output  1  output sample valid.
- out_data  output  WIDTH  registered in_data.
- out_m  output  MWIDTH  metadata paired with out_data.
- out_first  output  1  marks sample 0 of a frame (valid with out_nd).
- out_last  output  1  marks sample N-1 of a frame.
- error  output  1  sticky protocol error.

Behaviour:
- **Reset:** rst_n low asynchronously clears all of the following:
  - state=FILL, wcount=0, rcount=0.
  - mstore_read=0, out_nd=0, out_first=0, out_last=0, error=0.
  - out_data=0, out_m=0.
  - Reset mid-frame abandons the frame silently; the store must be reset together with this block.
- **Counters:** wcount and rcount are clog2(N) bits wide. Each wraps from N-1 to 0.
- **FILL state:**
  - Each in_m_nd increments wcount.
  - On the in_m_nd that takes wcount from N-1 to 0, state becomes DRAIN from the next cycle.
  - in_nd in FILL sets error; the sample is dropped, with no out_nd and no read.
- **DRAIN state:**
  - An in_nd accepted in cycle t registers in_data->out_data and mstore_m->out_m.
  - It sets out_nd=1 in cycle t+1 and mstore_read=1 in cycle t+1, so latency is 1 cycle.
  - mstore_m sampled in any cycle is the entry for the sample being accepted. With the read low the store shows RAM[addr]; with the read high it shows RAM[addr+1], i.e. the next entry. Back-to-back in_nd therefore needs no stall.
  - rcount increments with every mstore_read pulse.
  - out_first=1 when the pulse's rcount is 0; out_last=1 when it is N-1.
  - The cycle that issues the read with rcount=N-1 is the final cycle of DRAIN; state=FILL from the next cycle.
  - Samples accepted after the Nth in a frame are errors: in_nd in the cycle the Nth read is pulsed sets error and is dropped.
- **Write during drain:** in_m_nd while state=DRAIN, including the cycle of the final read pulse, sets error and does not increment wcount. The store also flags this case.
- **Simultaneous events:**
  - in_m_nd and in_nd together in FILL: the write counts and the in_nd is an error.
  - In DRAIN: both flag error.
- **Sticky error:** error stays high until reset. Datapath operation continues after an error.
- **Output qualification:** out_nd, out_first and out_last are single-cycle pulses. out_data and out_m hold their values between pulses.

Test Plan:
- **Basic frame:** N=4. Write m=1,0,1,1 on four consecutive cycles, then in_data=10,11,12,13 back-to-back.
  - out_nd for 4 cycles with (10,1),(11,0),(12,1),(13,1).
  - out_first on 10, out_last on 13.
  - mstore_read high 4 consecutive cycles, error=0.
- **Gapped drain:** same as basic, but in_nd asserted only every third cycle. Same pairs and markers as basic; mstore_read pulses exactly one cycle after each in_nd.
- **Two frames back-to-back:** write 4, drain 4, write 4 new values (0,0,1,0), drain 4.
  - Second frame pairs use the new metadata.
  - State returns to FILL exactly after the 4th read, error=0.
- **Early sample:** in_nd after only 3 metadata writes -> error=1, no out_nd, no mstore_read.
- **Late write:** in_m_nd in the same cycle as the 4th mstore_read -> error=1, and wcount stays 0 in the next FILL.
- **Async reset mid-drain:** pull rst_n low between clock edges after 2 samples.
  - All outputs go to 0 immediately, without waiting for a clock edge.
  - After release, a full basic-frame sequence passes cleanly.
